// File: rtl/seg7_scan_ctrl_if.sv
// Display bus between the CPU board top and the 7-segment scan controller.
// The producer side (master) presents the value to show plus the per-digit
// attributes and a load strobe; the controller (slave) returns the digit
// enables, the segment pattern and a once-per-frame tick.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] disp_data;
    logic                load;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic [DIGITS-1:0]   dp_mask;
    logic                lz_en;
    logic [DIGITS-1:0]   pos_ctrl;
    logic [7:0]          num_ctrl;
    logic                frame_tick;

    modport master (
        output disp_data,
        output load,
        output blank_mask,
        output blink_mask,
        output dp_mask,
        output lz_en,
        input  pos_ctrl,
        input  num_ctrl,
        input  frame_tick
    );

    modport slave (
        input  disp_data,
        input  load,
        input  blank_mask,
        input  blink_mask,
        input  dp_mask,
        input  lz_en,
        output pos_ctrl,
        output num_ctrl,
        output frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display controller.
// Everything runs on the board clock: a prescaler produces one digit slot
// every SCAN_DIV clocks, the digit index walks across the display, and a
// frame counter derives the blink phase. Display inputs are only consumed
// through shadow registers captured on load, so a frame never shows a mix
// of old and new values. Each slot starts with GUARD clocks of all digits
// off so the previous digit's segments cannot ghost onto the next one.
// Segment and digit drives are active low and fully registered.
module seg7_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 131072,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 CLK,
    input  logic                 Reset,
    seg7_scan_ctrl_if.slave      disp
);

    localparam int PRE_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IDX_W = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    // Shadow copies of the display inputs
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_blank;
    logic [DIGITS-1:0]   sh_blink;
    logic [DIGITS-1:0]   sh_dp;
    logic                sh_lz;

    // Scan timing state
    logic [PRE_W-1:0]    prescaler;
    logic [IDX_W-1:0]    idx;
    logic [FRM_W-1:0]    frame_cnt;
    logic                blink_phase;

    // Combinational helpers
    logic                slot_wrap;
    logic                frame_wrap;
    logic [DIGITS-1:0]   lz_supp;
    logic                higher_zero;
    logic [3:0]          cur_nibble;
    logic                visible;
    logic [DIGITS-1:0]   next_pos;
    logic [7:0]          next_num;

    // Registered outputs
    logic [DIGITS-1:0]   pos_q;
    logic [7:0]          num_q;
    logic                tick_q;

    // Active-low segment pattern g..a for one hex nibble, dp excluded
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] pat;
        case (v)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    // Capture the display inputs only when the producer strobes load
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sh_data  <= '0;
            sh_blank <= '0;
            sh_blink <= '0;
            sh_dp    <= '0;
            sh_lz    <= 1'b0;
        end else if (disp.load) begin
            sh_data  <= disp.disp_data;
            sh_blank <= disp.blank_mask;
            sh_blink <= disp.blink_mask;
            sh_dp    <= disp.dp_mask;
            sh_lz    <= disp.lz_en;
        end
    end

    // End-of-slot and end-of-frame conditions from the current scan position
    always_comb begin
        slot_wrap  = (prescaler == PRE_LAST);
        frame_wrap = slot_wrap && (idx == IDX_LAST);
    end

    // Prescaler: one digit slot every SCAN_DIV clocks
    always_ff @(posedge CLK) begin
        if (Reset) begin
            prescaler <= '0;
        end else if (slot_wrap) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Digit index steps once per slot and wraps after the last digit
    always_ff @(posedge CLK) begin
        if (Reset) begin
            idx <= '0;
        end else if (frame_wrap) begin
            idx <= '0;
        end else if (slot_wrap) begin
            idx <= idx + 1'b1;
        end
    end

    // Frame counter flips the blink phase after BLINK_FRAMES whole frames,
    // so the new phase applies from digit 0 of the following frame
    always_ff @(posedge CLK) begin
        if (Reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Leading-zero suppression: a digit hides when it and every digit above
    // it are zero; digit 0 always stays so a zero value still shows "0"
    always_comb begin
        lz_supp     = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (sh_data[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_supp[i] = sh_lz & higher_zero;
            end
        end
    end

    // Decide whether the current digit is lit and build the next drive values
    always_comb begin
        cur_nibble = sh_data[{idx, 2'b00} +: 4];
        visible    = (prescaler >= PRE_GUARD)
                     && !sh_blank[idx]
                     && !(blink_phase && sh_blink[idx])
                     && !lz_supp[idx];
        next_pos   = '1;
        next_num   = 8'hFF;
        if (visible) begin
            next_pos = ~(DIGITS'(1) << idx);
            next_num = {~sh_dp[idx], seg_decode(cur_nibble)};
        end
    end

    // Output registers: one clock behind the scan state
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pos_q  <= '1;
            num_q  <= 8'hFF;
            tick_q <= 1'b0;
        end else begin
            pos_q  <= next_pos;
            num_q  <= next_num;
            tick_q <= frame_wrap;
        end
    end

    assign disp.pos_ctrl   = pos_q;
    assign disp.num_ctrl   = num_q;
    assign disp.frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed 7-segment display controller for the board-level top of the single-cycle CPU. It replaces the fixed 4-digit display path with a fully synchronous block on the board clock. It generates the digit-scan rate internally from an enable counter rather than a derived clock. It adds double-buffered load, leading-zero suppression, per-digit blank/blink/decimal-point control, and anti-ghosting guard time.

## Interface
Parameters:
- DIGITS, 4: number of digits; legal range 1..8.
- SCAN_DIV, 131072: board clocks per digit slot. The default gives about 190 Hz frame rate for 4 digits at 100 MHz. Must be at least GUARD+2.
- GUARD, 2: clocks at the start of each slot with all digits off.
- BLINK_FRAMES, 64: number of frames per blink-phase toggle.

Ports:
- CLK  in  1  board clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- disp_data  in  4*DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is disp_data[3:0].
- load  in  1  when high at a clock edge, latches disp_data, blank_mask, blink_mask, dp_mask and lz_en into the shadow registers.
- blank_mask  in  DIGITS  when bit i is 1, digit i is always off.
- blink_mask  in  DIGITS  when bit i is 1, digit i is off during blink phase 1.
- dp_mask  in  DIGITS  when bit i is 1, the decimal point is lit on digit i.
- lz_en  in  1  enables leading-zero suppression.
- pos_ctrl  out  DIGITS  active-low digit enables; pos_ctrl[i] controls digit i.
- num_ctrl  out  8  active-low segments: bit 7 is dp, bits 6:0 are g,f,e,d,c,b,a.
- frame_tick  out  1  one-cycle pulse at frame wrap.

## Operation
- Shadow registers:
  - All display inputs are used only through the shadow registers; the display never tears mid-frame.
  - Shadow registers update only on a clock edge where load is high.
  - Reset clears all shadow registers to 0.
- Counters:
  - Prescaler runs 0..SCAN_DIV-1 and wraps.
  - Digit index idx advances on prescaler wrap, runs 0..DIGITS-1, and wraps to 0.
  - Frame counter counts idx wraps. blink_phase toggles when BLINK_FRAMES frames have completed, then the frame counter restarts.
- Digit visibility. Digit idx is visible when all of the following hold:
  - the prescaler is at or above GUARD;
  - blank_mask[idx] is 0;
  - not (blink_phase is 1 and blink_mask[idx] is 1);
  - the digit is not leading-zero suppressed.
- Leading-zero suppression: with lz_en set, digit i is suppressed if nibble i and every higher nibble are 0. Digit 0 is never suppressed, so an all-zero value shows a single "0".
- Decode, num_ctrl[6:0] per nibble value:
  - 0 → C0, 1 → F9, 2 → A4, 3 → B0, 4 → 99, 5 → 92, 6 → 82, 7 → F8
  - 8 → 80, 9 → 90, A → 88, b → 83, C → C6, d → A1, E → 86, F → 8E
  - These are the full 8-bit values with dp off (bit 7 = 1).
- num_ctrl[7] is the inverse of dp_mask[idx].
- Output values:
  - Visible digit: pos_ctrl has only bit idx low; num_ctrl carries the decoded pattern.
  - Not visible: pos_ctrl is all ones; num_ctrl is 8'hFF.
- frame_tick is high for the one cycle in which idx wraps from DIGITS-1 to 0.

## Timing
- All outputs are registered, with one clock of latency from internal state.
- Reset values:
  - pos_ctrl all ones, num_ctrl 8'hFF, frame_tick 0.
  - Prescaler, idx, frame counter and blink_phase all 0.
- Counting from the first edge with Reset low as edge 1, digit i is driven on edges i*SCAN_DIV+GUARD+1 through (i+1)*SCAN_DIV inclusive, for i = 0..DIGITS-1. Frame period is DIGITS*SCAN_DIV clocks.
- load sampled at edge E → the new value appears on num_ctrl at edge E+1, provided the digit is visible then. There is no busy or acknowledge signal; load may be asserted on every cycle.
- Reset held together with load: Reset wins and the shadow registers stay 0.
- Reset mid-frame: on the next edge outputs return to their reset values and the scan restarts from digit 0, guard first.
- The blink toggle coincides with the frame_tick cycle. It takes effect starting with digit 0 of the new frame.
- DIGITS=1: idx stays 0 and frame_tick pulses once per SCAN_DIV clocks.

## Test plan
- Reset: hold Reset for 3 cycles with inputs random → pos_ctrl=4'hF, num_ctrl=8'hFF, frame_tick=0 throughout and on the first edge after release.
- Scan and decode: DIGITS=4, SCAN_DIV=4, GUARD=1; load 16'habc7 → digits 0..3 show F8, C6, 83, 88, each for 3 clocks after 1 clock of all-off. The pos_ctrl low bit walks 0→1→2→3, and frame_tick pulses every 16 clocks.
- Leading zeros: lz_en=1, load 16'h0040 → digits 3 and 2 are off, digit 1 shows 99, digit 0 shows C0. Then load 16'h0000 → only digit 0 is lit, showing C0.
- Masks: blank_mask=4'b0010, dp_mask=4'b0001, data 16'h1234 → digit 1 is never enabled; digit 0 shows 8'h19 (pattern 99 with dp lit).
- Blink: BLINK_FRAMES=2, blink_mask=4'b1000 → digit 3 is lit for 2 frames, off for 2 frames, and repeats; other digits are unaffected.
- Double buffering: change disp_data with load=0 for one full frame → outputs unchanged. Pulse load mid-slot → num_ctrl changes exactly one edge later.
